alu_serial_addsub: RTL and testbench
====================================

ALU_SERIAL_ADDSUB -- requirements
Module: alu_serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant: DIGITS = WIDTH/4, the number of nibbles processed.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; accepted only when ready=1.
REQ-006 op  input  2  operation: 00 ADC, 01 SBC, 10 CMP, 11 SUB (SBC with carry-in forced 1).
REQ-007 decimal  input  1  BCD mode for ADC/SBC; ignored for CMP and SUB.
REQ-008 cin  input  1  carry flag in; ignored for CMP and SUB.
REQ-009 a  input  WIDTH  accumulator operand.
REQ-010 b  input  WIDTH  memory/immediate operand.
REQ-011 ready  output  1  idle and able to accept start.
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 result  output  WIDTH  registered result.
REQ-015 flags  output  8  6502 layout: bit7 N, bit6 V, bit1 Z, bit0 C; all other bits 0.

Function
REQ-016 a, b, op, decimal and cin SHALL be latched on the edge where start=1 and ready=1; later input changes SHALL have no effect on the operation.
REQ-017 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on an accepted start; RUN->DONE after DIGITS cycles; DONE->RUN on an accepted start, else DONE->IDLE.
REQ-018 RUN SHALL process one nibble per cycle, LSB nibble first, with the carry/borrow propagated between nibbles in a register.
REQ-019 Carry-in SHALL be cin for ADC/SBC and 1 for CMP/SUB.
REQ-020 Binary mode: ADC SHALL compute a+b+c; SBC/CMP/SUB SHALL compute a+~b+c; C SHALL be the carry out of bit WIDTH-1.
REQ-021 Decimal ADC, per nibble: s=a_i+b_i+c; if s>9 then s+=6 and carry out=1.
REQ-022 Decimal SBC, per nibble: d=a_i-b_i-(1-c); if d<0 then d+=10 and borrow out=1; C SHALL equal NOT(final borrow).
REQ-023 V SHALL equal the signed overflow of the unadjusted binary operation, in both modes; a binary carry chain SHALL run in parallel with the decimal chain.
REQ-024 N SHALL equal result[WIDTH-1] and Z SHALL equal (result==0), both taken from the final value.
REQ-025 CMP SHALL update N, Z and C only; result and V SHALL retain their previous values.
REQ-026 result and flags SHALL update on the edge entering DONE; done=1 and ready=1 SHALL hold during DONE.
REQ-027 Latency: start accepted at edge E0; done SHALL be high in the cycle following edge E(DIGITS).
REQ-028 ready SHALL be 1 in IDLE and DONE and 0 in RUN; busy SHALL be 1 only in RUN.
REQ-029 start while busy=1 SHALL be ignored and not queued.
REQ-030 start asserted during DONE SHALL be accepted back-to-back, with no idle cycle.

Reset
REQ-031 On reset: state=IDLE, result=0, flags=0, done=0, busy=0, ready=1.
REQ-032 Reset during RUN SHALL abort the operation with no partial update of result or flags.

Structure
REQ-033 Package alu6502_pkg SHALL hold the op encodings, flag bit positions and the FSM state enum.
REQ-034 Sub-module bcd_digit SHALL implement the combinational one-nibble add/sub with decimal adjust, returning the adjusted digit, decimal carry and binary carry; it SHALL be instantiated once.

Verification
REQ-035 WIDTH=8, SBC binary, a=02, b=00, cin=0 -> result=01, flags=01, done 2 cycles after start.
REQ-036 WIDTH=8, ADC binary, a=7F, b=01, cin=0 -> result=80, flags=C0.
REQ-037 WIDTH=8, ADC decimal, a=58, b=46, cin=1 -> result=05, C=1, Z=0.
REQ-038 WIDTH=8, CMP, a=10, b=10, with prior result=55 -> result stays 55, Z=1, C=1, N=0.
REQ-039 WIDTH=16, SBC decimal, a=1000, b=0001, cin=1 -> result=0999, C=1, done 4 cycles after start.
REQ-040 Reset pulse in the 2nd RUN cycle -> result=0, flags=0, ready=1; a second start during busy is ignored and a start during DONE is accepted back-to-back.

Source files
------------

// File: rtl/alu_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial 6502-style add/subtract unit:
// operation encodings, flag bit positions and controller states.
package alu6502_pkg;

    typedef enum logic [1:0] {
        OP_ADC = 2'b00,
        OP_SBC = 2'b01,
        OP_CMP = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ADC and SBC honour the carry input and decimal mode; CMP and SUB do not.
    function automatic logic op_uses_cin(input op_t op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_serial_addsub_bcd_digit.sv
// One-nibble adder/subtractor. The binary and decimal carry chains are
// evaluated side by side so the caller can derive overflow from the
// unadjusted binary sum while the digit itself may be decimal-adjusted.
module bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       decimal,
    input  logic       cin_dec,
    input  logic       cin_bin,
    output logic [3:0] digit,
    output logic       cout_dec,
    output logic       cout_bin,
    output logic       sum_msb
);

    logic [3:0] b_eff;
    logic [4:0] bin_full;
    logic [4:0] add_raw;
    logic [4:0] sub_raw;
    logic [3:0] dec_digit;
    logic       dec_carry;

    // Binary nibble sum plus decimal add/subtract with adjust, then mode select.
    always_comb begin
        b_eff    = sub ? ~b : b;
        bin_full = {1'b0, a} + {1'b0, b_eff} + {4'b0, cin_bin};
        cout_bin = bin_full[4];
        sum_msb  = bin_full[3];

        add_raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin_dec};
        // Two's-complement difference; bit 4 set means the digit went negative.
        sub_raw  = {1'b0, a} - {1'b0, b} - {4'b0, ~cin_dec};

        dec_digit = '0;
        dec_carry = 1'b0;
        if (!sub) begin
            if (add_raw > 5'd9) begin
                dec_digit = add_raw[3:0] + 4'd6;
                dec_carry = 1'b1;
            end else begin
                dec_digit = add_raw[3:0];
                dec_carry = 1'b0;
            end
        end else begin
            if (sub_raw[4]) begin
                dec_digit = sub_raw[3:0] + 4'd10;
                dec_carry = 1'b0;
            end else begin
                dec_digit = sub_raw[3:0];
                dec_carry = 1'b1;
            end
        end

        digit    = decimal ? dec_digit : bin_full[3:0];
        cout_dec = decimal ? dec_carry : bin_full[4];
    end

endmodule

// File: rtl/alu_serial_addsub.sv
// Nibble-serial ADC/SBC/CMP/SUB unit with 6502 flag semantics. Operands are
// latched on an accepted start and processed one nibble per cycle, LSB first.
module alu_serial_addsub
    import alu6502_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             decimal,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags
);

    localparam int unsigned DIGITS = WIDTH / 4;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
        $error("alu_serial_addsub: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    op_t              op_q;
    logic             dec_q;
    logic             c_dec;
    logic             c_bin;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;
    logic             sub;
    logic             op_is_cmp;
    logic             v_ovf;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;
    logic             flag_c;
    logic [3:0]       digit;
    logic             cout_dec;
    logic             cout_bin;
    logic             sum_msb;

    bcd_digit u_digit (
        .a        (a_sh[3:0]),
        .b        (b_sh[3:0]),
        .sub      (sub),
        .decimal  (dec_q),
        .cin_dec  (c_dec),
        .cin_bin  (c_bin),
        .digit    (digit),
        .cout_dec (cout_dec),
        .cout_bin (cout_bin),
        .sum_msb  (sum_msb)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE can chain straight into another RUN.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  busy  = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // Per-cycle datapath terms: the partial result shifts in from the top, and
    // overflow is judged on the top nibble using the unadjusted binary sum bit.
    always_comb begin
        accept    = start && ready;
        last      = (cnt == LAST_CNT);
        sub       = (op_q != OP_ADC);
        op_is_cmp = (op_q == OP_CMP);
        acc_next  = WIDTH'({digit, acc} >> 4);
        v_ovf     = (a_sh[3] == (b_sh[3] ^ sub)) && (sum_msb != a_sh[3]);
    end

    // Operand latching, nibble stepping and commit of result/flags on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            op_q   <= OP_ADC;
            dec_q  <= 1'b0;
            c_dec  <= 1'b0;
            c_bin  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            op_q  <= op_t'(op);
            dec_q <= decimal && op_uses_cin(op_t'(op));
            c_dec <= op_uses_cin(op_t'(op)) ? cin : 1'b1;
            c_bin <= op_uses_cin(op_t'(op)) ? cin : 1'b1;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            acc   <= acc_next;
            c_dec <= cout_dec;
            c_bin <= cout_bin;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                if (!op_is_cmp) begin
                    result <= acc_next;
                    flag_v <= v_ovf;
                end
                flag_n <= acc_next[WIDTH-1];
                flag_z <= (acc_next == '0);
                flag_c <= cout_dec;
            end
        end
    end

    // Assemble the 6502 status byte; unused positions read as zero.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = flag_n;
        flags[FLAG_V] = flag_v;
        flags[FLAG_Z] = flag_z;
        flags[FLAG_C] = flag_c;
    end

endmodule

// File: tb/tb_alu_serial_addsub.sv
// Bench for alu_serial_addsub: an 8-bit and a 16-bit instance checked every
// cycle against an arithmetic reference model, plus hand-computed vectors.
module tb_alu_serial_addsub;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        decimal = 1'b0;
    logic        cin = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;

    logic        ready8, busy8, done8;
    logic [7:0]  result8, flags8;
    logic        ready16, busy16, done16;
    logic [15:0] result16;
    logic [7:0]  flags16;

    int n_checks = 0;
    int n_fail = 0;

    alu_serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .decimal(decimal),
        .cin(cin), .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8),
        .result(result8), .flags(flags8)
    );

    alu_serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .decimal(decimal),
        .cin(cin), .a(a16), .b(b16), .ready(ready16), .busy(busy16), .done(done16),
        .result(result16), .flags(flags16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: whole-word binary sum for value/carry/overflow,
    // digit-by-digit BCD rules when decimal mode applies.
    function automatic void model_op(input int w, input int o, input bit d, input bit c,
                                     input int a, input int b, input int pr, input int pf,
                                     output int res, output int fl);
        int mask = (1 << w) - 1;
        bit sb = (o != 0);
        int ce = (o < 2) ? int'(c) : 1;
        bit ud = d && (o < 2);
        int be = sb ? (~b & mask) : b;
        int bin = a + be + ce;
        int bres = bin & mask;
        int val, cf, vf, nf, zf, carry, ai, bi, s;
        vf = ((((a >> (w-1)) & 1) == ((be >> (w-1)) & 1)) &&
              (((bres >> (w-1)) & 1) != ((a >> (w-1)) & 1))) ? 1 : 0;
        if (!ud) begin
            val = bres;
            cf  = (bin >> w) & 1;
        end else begin
            carry = ce;
            val = 0;
            for (int i = 0; i < w/4; i++) begin
                ai = (a >> (4*i)) & 15;
                bi = (b >> (4*i)) & 15;
                if (o == 0) begin
                    s = ai + bi + carry;
                    if (s > 9) begin s += 6; carry = 1; end else carry = 0;
                end else begin
                    s = ai - bi - (1 - carry);
                    if (s < 0) begin s += 10; carry = 0; end else carry = 1;
                end
                val |= (s & 15) << (4*i);
            end
            cf = carry;
        end
        nf = (val >> (w-1)) & 1;
        zf = (val == 0) ? 1 : 0;
        if (o == 2) begin
            res = pr;
            fl  = (nf << 7) | (pf & 'h40) | (zf << 1) | cf;
        end else begin
            res = val;
            fl  = (nf << 7) | (vf << 6) | (zf << 1) | cf;
        end
    endfunction

    // Model state per instance: phase 0 idle, 1 run, 2 done.
    int ph[2], rem[2], mres[2], mflg[2], pres[2], pflg[2];
    int m_w, m_a, m_b;
    bit m_st;

    initial begin
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; rem[i] = 0; mres[i] = 0; mflg[i] = 0; pres[i] = 0; pflg[i] = 0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = 0; rem[i] = 0; mres[i] = 0; mflg[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_st = (i == 0) ? start8 : start16;
                m_w  = (i == 0) ? 8 : 16;
                m_a  = (i == 0) ? int'(a8) : int'(a16);
                m_b  = (i == 0) ? int'(b8) : int'(b16);
                if (ph[i] == 1) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        ph[i] = 2;
                        mres[i] = pres[i];
                        mflg[i] = pflg[i];
                    end
                end else if (m_st) begin
                    model_op(m_w, int'(op), decimal, cin, m_a, m_b, mres[i], mflg[i], pres[i], pflg[i]);
                    ph[i] = 1;
                    rem[i] = m_w / 4;
                end else begin
                    ph[i] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if ($time > 2) begin
            check("ready8",   16'(ready8),   16'(ph[0] != 1));
            check("busy8",    16'(busy8),    16'(ph[0] == 1));
            check("done8",    16'(done8),    16'(ph[0] == 2));
            check("result8",  16'(result8),  16'(mres[0]));
            check("flags8",   16'(flags8),   16'(mflg[0]));
            check("ready16",  16'(ready16),  16'(ph[1] != 1));
            check("busy16",   16'(busy16),   16'(ph[1] == 1));
            check("done16",   16'(done16),   16'(ph[1] == 2));
            check("result16", result16,      16'(mres[1]));
            check("flags16",  16'(flags16),  16'(mflg[1]));
        end
    end

    // Issue one operation, scramble inputs after acceptance, wait for done.
    task automatic do_op(input int sel, input logic [1:0] o, input logic d, input logic c,
                         input logic [15:0] aa, input logic [15:0] bb, output int cyc);
        logic dn;
        @(negedge clk); #1;
        op = o; decimal = d; cin = c;
        if (sel == 0) begin a8 = aa[7:0]; b8 = bb[7:0]; start8 = 1'b1; end
        else begin a16 = aa; b16 = bb; start16 = 1'b1; end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        op = 2'($urandom); decimal = 1'($urandom); cin = 1'($urandom);
        cyc = 0;
        while (cyc <= 20) begin
            @(negedge clk);
            dn = (sel == 0) ? done8 : done16;
            if (dn) break;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        check("rst_result8", 16'(result8), 16'h0000);
        check("rst_flags8",  16'(flags8),  16'h0000);
        check("rst_ready8",  16'(ready8),  16'h0001);

        do_op(0, 2'b01, 1'b0, 1'b0, 16'h02, 16'h00, cyc);
        check("sbc_lat",  16'(cyc), 16'd2);
        check("sbc_res",  16'(result8), 16'h01);
        check("sbc_flg",  16'(flags8),  16'h01);

        do_op(0, 2'b00, 1'b0, 1'b0, 16'h7F, 16'h01, cyc);
        check("adc_ovf_res", 16'(result8), 16'h80);
        check("adc_ovf_flg", 16'(flags8),  16'hC0);

        do_op(0, 2'b00, 1'b1, 1'b1, 16'h58, 16'h46, cyc);
        check("adc_dec_res", 16'(result8), 16'h05);
        check("adc_dec_flg", 16'(flags8),  16'h41);

        do_op(0, 2'b00, 1'b0, 1'b0, 16'h50, 16'h05, cyc);
        check("adc_55_res", 16'(result8), 16'h55);
        check("adc_55_flg", 16'(flags8),  16'h00);

        do_op(0, 2'b10, 1'b1, 1'b0, 16'h10, 16'h10, cyc);
        check("cmp_res", 16'(result8), 16'h55);
        check("cmp_flg", 16'(flags8),  16'h03);

        do_op(0, 2'b11, 1'b1, 1'b0, 16'h05, 16'h07, cyc);
        check("sub_res", 16'(result8), 16'hFE);
        check("sub_flg", 16'(flags8),  16'h80);

        do_op(1, 2'b01, 1'b1, 1'b1, 16'h1000, 16'h0001, cyc);
        check("sbc16_lat", 16'(cyc), 16'd4);
        check("sbc16_res", result16, 16'h0999);
        check("sbc16_flg", 16'(flags16), 16'h01);

        do_op(1, 2'b00, 1'b1, 1'b0, 16'h9999, 16'h0001, cyc);
        check("adc16_res", result16, 16'h0000);
        check("adc16_flg", 16'(flags16), 16'h03);

        // Reset in the second RUN cycle aborts without touching result/flags.
        @(negedge clk); #1;
        op = 2'b00; decimal = 1'b0; cin = 1'b0; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); #1 reset = 1'b1;
        #2;
        check("abort_result", 16'(result8), 16'h0000);
        check("abort_flags",  16'(flags8),  16'h0000);
        check("abort_ready",  16'(ready8),  16'h0001);
        check("abort_busy",   16'(busy8),   16'h0000);
        @(negedge clk); #1 reset = 1'b0;

        // Start held through RUN is ignored; start in DONE chains immediately.
        @(negedge clk); #1;
        op = 2'b00; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk); #1 a8 = 8'h99; b8 = 8'h99;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done1", 16'(done8),   16'h0001);
        check("b2b_res1",  16'(result8), 16'h33);
        check("b2b_flg1",  16'(flags8),  16'h00);
        #1 a8 = 8'h01; b8 = 8'h02;
        @(posedge clk); #1 start8 = 1'b0;
        @(negedge clk);
        check("b2b_busy",  16'(busy8), 16'h0001);
        check("b2b_nodone", 16'(done8), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("b2b_done2", 16'(done8),   16'h0001);
        check("b2b_res2",  16'(result8), 16'h03);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
